// File: rtl/rain_pkg.sv
// Shared types and default constants for the multi-zone rain controller.
// Optional feature macro: RAIN_ALERT_EVTCNT_EN (per-zone WET-entry event counters).
package rain_pkg;

   // Per-zone debounce state
   typedef enum logic [1:0] {
      DRY      = 2'd0,
      WET_PEND = 2'd1,
      WET      = 2'd2,
      DRY_PEND = 2'd3
   } zone_state_t;

   localparam int DEF_N_ZONES     = 4;
   localparam int DEF_DEB_CYCLES  = 16;
   localparam int DEF_DRY_HOLD    = 1024;
   localparam int DEF_BUZZ_CYCLES = 256;

   // Larger of two integers, used to size the shared debounce counter
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rain_zone_fsm.sv
// Single-zone rain debounce FSM: DEB_CYCLES consecutive wet samples declare rain,
// DRY_HOLD consecutive dry samples clear it. One counter serves both directions.
module rain_zone_fsm
   import rain_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int DRY_HOLD   = DEF_DRY_HOLD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample,
   output zone_state_t state,
   output logic        wet_enter
);

   localparam int CNT_W = $clog2(max_int(DEB_CYCLES, DRY_HOLD) + 1);
   // Thresholds are compared before the increment, so the last sample of a run
   // is the one that moves the FSM; >= keeps the counter bounded for a value of 1.
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRY_LAST = CNT_W'(DRY_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   zone_state_t      state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // State and run-length counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DRY;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and counter update; wet_enter flags the WET_PEND->WET step
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wet_enter = 1'b0;
      unique case (state)
         DRY: begin
            if (sample) begin
               state_nxt = WET_PEND;
               cnt_nxt   = CNT_ONE;
            end
         end
         WET_PEND: begin
            if (!sample) begin
               state_nxt = DRY;
               cnt_nxt   = '0;
            end else if (cnt >= DEB_LAST) begin
               state_nxt = WET;
               cnt_nxt   = '0;
               wet_enter = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         WET: begin
            if (!sample) begin
               state_nxt = DRY_PEND;
               cnt_nxt   = CNT_ONE;
            end
         end
         DRY_PEND: begin
            if (sample) begin
               state_nxt = WET;
               cnt_nxt   = '0;
            end else if (cnt >= DRY_LAST) begin
               state_nxt = DRY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = DRY;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/multi_zone_rain_ctrl.sv
// Multi-zone rain controller: synchronises raw sensors, debounces each zone,
// drives per-zone LEDs and valve gating, and a shared acknowledgeable buzzer.
// Optional feature macro: RAIN_ALERT_EVTCNT_EN adds evt_cnt (8-bit saturating
// WET-entry counter per zone).
module multi_zone_rain_ctrl
   import rain_pkg::*;
#(
   parameter int N_ZONES     = DEF_N_ZONES,
   parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
   parameter int DRY_HOLD    = DEF_DRY_HOLD,
   parameter int BUZZ_CYCLES = DEF_BUZZ_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_ZONES-1:0] rain_sensor,
   input  logic [N_ZONES-1:0] irr_req,
   input  logic               buzz_ack,
   output logic [N_ZONES-1:0] led,
   output logic [N_ZONES-1:0] irrigation_en,
   output logic               buzzer,
   output logic               any_rain
`ifdef RAIN_ALERT_EVTCNT_EN
   ,
   output logic [N_ZONES*8-1:0] evt_cnt
`endif
);

   localparam int TMR_W = $clog2(BUZZ_CYCLES + 1);
   localparam logic [TMR_W-1:0] BUZZ_LOAD = TMR_W'(BUZZ_CYCLES);
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

   logic [N_ZONES-1:0] sync_p0;
   logic [N_ZONES-1:0] sync_p1;
   zone_state_t        zone_state [N_ZONES];
   logic [N_ZONES-1:0] wet_enter;
   logic [N_ZONES-1:0] wet_entry_p2;
   logic [TMR_W-1:0]   timer;

   // Stage p0/p1: two-flop synchroniser for the asynchronous sensors
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= rain_sensor;
         sync_p1 <= sync_p0;
      end
   end

   // Stage p2: one debounce FSM per zone
   for (genvar g = 0; g < N_ZONES; g++) begin : g_zone
      rain_zone_fsm #(
         .DEB_CYCLES (DEB_CYCLES),
         .DRY_HOLD   (DRY_HOLD)
      ) u_fsm (
         .clk       (clk),
         .rst       (rst),
         .sample    (sync_p1[g]),
         .state     (zone_state[g]),
         .wet_enter (wet_enter[g])
      );
   end

   // Stage p3: registered LED decode and valve gating; entry pulse aligned with LED
   always_ff @(posedge clk) begin
      if (rst) begin
         led           <= '0;
         irrigation_en <= '0;
         wet_entry_p2  <= '0;
      end else begin
         wet_entry_p2 <= wet_enter;
         for (int i = 0; i < N_ZONES; i++) begin
            led[i]           <= (zone_state[i] == WET) || (zone_state[i] == DRY_PEND);
            irrigation_en[i] <= irr_req[i] &&
                                ((zone_state[i] == DRY) || (zone_state[i] == WET_PEND));
         end
      end
   end

   // Shared buzzer timer: any new WET entry reloads (and beats ack); ack silences
   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= '0;
      end else if (|wet_entry_p2) begin
         timer <= BUZZ_LOAD;
      end else if (buzz_ack) begin
         timer <= '0;
      end else if (timer != '0) begin
         timer <= timer - TMR_ONE;
      end
   end

   assign buzzer   = (timer != '0);
   assign any_rain = |led;

`ifdef RAIN_ALERT_EVTCNT_EN
   // Saturating 8-bit increment
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [7:0] evt_q [N_ZONES];

   // Per-zone WET-entry event counters
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ZONES; i++) evt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_ZONES; i++) begin
            if (wet_entry_p2[i]) evt_q[i] <= sat_inc8(evt_q[i]);
         end
      end
   end

   for (genvar g = 0; g < N_ZONES; g++) begin : g_evt
      assign evt_cnt[g*8 +: 8] = evt_q[g];
   end
`endif

endmodule

// File: doc/multi_zone_rain_ctrl.md
MULTI_ZONE_RAIN_CTRL -- requirements
Module: multi_zone_rain_ctrl

Interface
REQ-001 SHALL have parameter N_ZONES, default 4: number of independent sensor/irrigation zones, legal range 1..16.
REQ-002 SHALL have parameter DEB_CYCLES, default 16: consecutive wet samples required to declare rain, legal range >=1.
REQ-003 SHALL have parameter DRY_HOLD, default 1024: consecutive dry samples required to clear rain, legal range >=1.
REQ-004 SHALL have parameter BUZZ_CYCLES, default 256: buzzer on-time per alert, legal range >=1.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port rain_sensor, input, N_ZONES: asynchronous raw sensors, 1 = rain.
REQ-008 SHALL have port irr_req, input, N_ZONES: irrigation request per zone from the scheduler.
REQ-009 SHALL have port buzz_ack, input, 1: operator acknowledge; silences the buzzer.
REQ-010 SHALL have port led, output, N_ZONES: per-zone rain indicator.
REQ-011 SHALL have port irrigation_en, output, N_ZONES: per-zone valve enable.
REQ-012 SHALL have port buzzer, output, 1: audible alert.
REQ-013 SHALL have port any_rain, output, 1: OR of all led bits.

Function
REQ-014 SHALL pass each rain_sensor bit through a 2-flop synchroniser before any other use.
REQ-015 SHALL run one FSM per zone with states DRY, WET_PEND, WET, DRY_PEND.
REQ-016 DRY -> WET_PEND when synced sample = 1; counter loads 1.
REQ-017 WET_PEND: each further 1 increments; counter reaching DEB_CYCLES -> WET; any 0 -> DRY, counter cleared.
REQ-018 WET -> DRY_PEND when synced sample = 0; counter loads 1.
REQ-019 DRY_PEND: each further 0 increments; counter reaching DRY_HOLD -> DRY; any 1 -> WET, counter cleared.
REQ-020 Counter width SHALL be $clog2(max(DEB_CYCLES,DRY_HOLD)+1); counter never wraps.
REQ-021 led[i] SHALL be a registered decode, 1 in WET and DRY_PEND; first assertion DEB_CYCLES+3 cycles after rain_sensor[i] is first sampled high and held.
REQ-022 irrigation_en[i] SHALL be registered irr_req[i] AND (state DRY or WET_PEND); 0 in WET/DRY_PEND regardless of irr_req.
REQ-023 Any zone's WET_PEND->WET transition SHALL load a shared buzzer timer with BUZZ_CYCLES; buzzer = 1 while timer nonzero; timer decrements each cycle.
REQ-024 buzz_ack SHALL clear the timer next cycle; a new WET entry in the same cycle as buzz_ack SHALL win (timer reloads).
REQ-025 Simultaneous WET entries in several zones SHALL produce a single reload, not an extension.
REQ-026 any_rain SHALL be combinational OR of registered led.

Reset
REQ-027 rst SHALL force all FSMs to DRY, counters, timer and synchronisers to 0, and led, irrigation_en, buzzer, any_rain to 0 on the next edge.
REQ-028 rst asserted mid-debounce or mid-alert SHALL abandon it; no buzzer or led after rst deasserts until a fresh full debounce.

Configuration
REQ-029 With RAIN_ALERT_EVTCNT_EN defined, SHALL add output evt_cnt, N_ZONES*8: per-zone 8-bit counter incremented on each WET entry, saturating at 255, cleared by rst.
REQ-030 Without RAIN_ALERT_EVTCNT_EN, evt_cnt port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package rain_pkg SHALL hold the zone-state enum and default parameter constants.
REQ-032 Per-zone debounce FSM and counter SHALL be sub-module rain_zone_fsm, instantiated N_ZONES times by generate; synchronisers, buzzer timer, irrigation gating and evt_cnt in top.

Verification (N_ZONES=2, DEB_CYCLES=4, DRY_HOLD=8, BUZZ_CYCLES=5)
REQ-033 rain_sensor[0]=1 held -> led[0]=1 exactly 7 cycles later; buzzer high 5 cycles; any_rain=1; irrigation_en[0] drops with led[0].
REQ-034 rain_sensor[0] 1 for 3 cycles then 0 -> led[0], buzzer never assert.
REQ-035 In WET, sensor 0 for 5 cycles then 1 -> led[0] stays 1; sensor 0 held 8 -> led[0] falls, irrigation_en[0] follows irr_req[0].
REQ-036 Both zones reach WET same cycle -> buzzer high exactly 5 cycles; buzz_ack at cycle 2 -> buzzer 0 next cycle.
REQ-037 rst pulsed during WET_PEND and during buzzer -> all outputs 0 next cycle; full 7-cycle latency required afterwards.
REQ-038 With RAIN_ALERT_EVTCNT_EN, 300 rain episodes on zone 1 -> evt_cnt[15:8]=255, evt_cnt[7:0]=0.
